// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: active-low codes with dp=1 in bit 7,
// blank/off patterns and the per-digit field width.
package seg7_pkg;
   localparam int unsigned DIGIT_W = 4;

   localparam logic [7:0] SEG_0 = 8'hC0;
   localparam logic [7:0] SEG_1 = 8'hF9;
   localparam logic [7:0] SEG_2 = 8'hA4;
   localparam logic [7:0] SEG_3 = 8'hB0;
   localparam logic [7:0] SEG_4 = 8'h99;
   localparam logic [7:0] SEG_5 = 8'h92;
   localparam logic [7:0] SEG_6 = 8'h82;
   localparam logic [7:0] SEG_7 = 8'hF8;
   localparam logic [7:0] SEG_8 = 8'h80;
   localparam logic [7:0] SEG_9 = 8'h90;
   localparam logic [7:0] SEG_A = 8'h88;
   localparam logic [7:0] SEG_B = 8'h83;
   localparam logic [7:0] SEG_C = 8'hC6;
   localparam logic [7:0] SEG_D = 8'hA1;
   localparam logic [7:0] SEG_E = 8'h86;
   localparam logic [7:0] SEG_F = 8'h8E;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] ANODE_OFF = 8'hFF;
endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-low seven-segment pattern; i_blank
// forces all segments off.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [DIGIT_W-1:0] i_value,
   input  logic               i_blank,
   output logic [7:0]         o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      if (!i_blank) begin
         case (i_value)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            default: o_seg = SEG_F;
         endcase
      end
   end

endmodule

// File: rtl/multi_digit_counter_display.sv
// N-digit BCD/hex up/down counter with prescaled tick, wrap pulse and a
// time-multiplexed, registered seven-segment display scan.
module multi_digit_counter_display
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned BASE       = 10,
   parameter int unsigned COUNT_DIV  = 100000000,
   parameter int unsigned SCAN_DIV   = 100000,
   parameter bit          BLANK_LZ   = 1'b0
)(
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          En,
   input  logic                          Up,
   input  logic                          Clear,
   output logic [DIGIT_W*NUM_DIGITS-1:0] Count,
   output logic                          Wrap,
   output logic [7:0]                    display,
   output logic [7:0]                    Anode
);

   localparam int unsigned CW = (COUNT_DIV  > 1) ? $clog2(COUNT_DIV)  : 1;
   localparam int unsigned SW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DIGIT_W-1:0] DIG_MAX = DIGIT_W'(BASE - 1);

   logic [CW-1:0]                   r_cpre;
   logic [SW-1:0]                   r_spre;
   logic [IW-1:0]                   r_idx;
   logic [DIGIT_W*NUM_DIGITS-1:0]   r_count;
   logic                            r_wrap;
   logic [7:0]                      r_anode;
   logic [7:0]                      r_disp;

   logic                            w_tick;
   logic                            w_scan_step;
   logic [DIGIT_W*NUM_DIGITS-1:0]   w_next;
   logic [DIGIT_W-1:0]              w_dig;
   logic                            w_carry;
   logic [NUM_DIGITS-1:0]           w_lz;
   logic                            w_allz;
   logic [DIGIT_W-1:0]              w_sel_dig;
   logic                            w_sel_blank;
   logic [7:0]                      w_anode;
   logic [7:0]                      w_seg;

   assign w_tick      = En && (r_cpre == CW'(COUNT_DIV - 1));
   assign w_scan_step = (r_spre == SW'(SCAN_DIV - 1));

   // Ripple carry/borrow from digit 0; a carry out of the top digit is the wrap.
   always_comb begin
      w_next  = r_count;
      w_carry = 1'b1;
      w_dig   = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         w_dig = r_count[i*DIGIT_W +: DIGIT_W];
         if (w_carry) begin
            if (Up) begin
               if (w_dig == DIG_MAX) w_dig = '0;
               else begin
                  w_dig   = w_dig + 1'b1;
                  w_carry = 1'b0;
               end
            end else begin
               if (w_dig == '0) w_dig = DIG_MAX;
               else begin
                  w_dig   = w_dig - 1'b1;
                  w_carry = 1'b0;
               end
            end
         end
         w_next[i*DIGIT_W +: DIGIT_W] = w_dig;
      end
   end

   // Digit i is a leading zero when it and every digit above it are zero.
   always_comb begin
      w_lz   = '0;
      w_allz = 1'b1;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         w_allz = w_allz && (r_count[(NUM_DIGITS-1-k)*DIGIT_W +: DIGIT_W] == '0);
         w_lz[NUM_DIGITS-1-k] = BLANK_LZ && w_allz && (k != NUM_DIGITS - 1);
      end
   end

   always_comb begin
      w_sel_dig   = '0;
      w_sel_blank = 1'b0;
      w_anode     = ANODE_OFF;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (IW'(i) == r_idx) begin
            w_sel_dig   = r_count[i*DIGIT_W +: DIGIT_W];
            w_sel_blank = w_lz[i];
            w_anode[i]  = 1'b0;
         end
      end
   end

   seg7_decode u_dec (
      .i_value (w_sel_dig),
      .i_blank (w_sel_blank),
      .o_seg   (w_seg)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_cpre  <= '0;
         r_count <= '0;
         r_wrap  <= 1'b0;
      end else if (Clear) begin
         r_cpre  <= '0;
         r_count <= '0;
         r_wrap  <= 1'b0;
      end else if (En) begin
         r_cpre  <= w_tick ? '0 : r_cpre + 1'b1;
         r_wrap  <= w_tick && w_carry;
         if (w_tick) r_count <= w_next;
      end else begin
         r_wrap  <= 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_spre  <= '0;
         r_idx   <= '0;
         r_anode <= ANODE_OFF;
         r_disp  <= SEG_BLANK;
      end else begin
         r_anode <= w_anode;
         r_disp  <= w_seg;
         if (w_scan_step) begin
            r_spre <= '0;
            r_idx  <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
         end else begin
            r_spre <= r_spre + 1'b1;
         end
      end
   end

   assign Count   = r_count;
   assign Wrap    = r_wrap;
   assign display = r_disp;
   assign Anode   = r_anode;

endmodule

// File: tb/tb_multi_digit_counter_display.sv
// Directed bench: three instances (BCD, BCD with leading-zero blanking, hex),
// all 2 digits, COUNT_DIV=4, SCAN_DIV=2, sharing clock and reset.
module tb_multi_digit_counter_display;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;

   logic       a_en = 1'b0, a_up = 1'b1, a_clr = 1'b0;
   logic [7:0] a_count, a_disp, a_an;
   logic       a_wrap;

   logic       b_en = 1'b0, b_up = 1'b1, b_clr = 1'b0;
   logic [7:0] b_count, b_disp, b_an;
   logic       b_wrap;

   logic       c_en = 1'b0, c_up = 1'b1, c_clr = 1'b0;
   logic [7:0] c_count, c_disp, c_an;
   logic       c_wrap;

   int total = 0;
   int bad   = 0;
   int n_edge = 0;

   always #5 Clk = ~Clk;

   multi_digit_counter_display #(
      .NUM_DIGITS(2), .BASE(10), .COUNT_DIV(4), .SCAN_DIV(2), .BLANK_LZ(1'b0)
   ) u_a (
      .Clk(Clk), .Reset(Reset), .En(a_en), .Up(a_up), .Clear(a_clr),
      .Count(a_count), .Wrap(a_wrap), .display(a_disp), .Anode(a_an)
   );

   multi_digit_counter_display #(
      .NUM_DIGITS(2), .BASE(10), .COUNT_DIV(4), .SCAN_DIV(2), .BLANK_LZ(1'b1)
   ) u_b (
      .Clk(Clk), .Reset(Reset), .En(b_en), .Up(b_up), .Clear(b_clr),
      .Count(b_count), .Wrap(b_wrap), .display(b_disp), .Anode(b_an)
   );

   multi_digit_counter_display #(
      .NUM_DIGITS(2), .BASE(16), .COUNT_DIV(4), .SCAN_DIV(2), .BLANK_LZ(1'b0)
   ) u_c (
      .Clk(Clk), .Reset(Reset), .En(c_en), .Up(c_up), .Clear(c_clr),
      .Count(c_count), .Wrap(c_wrap), .display(c_disp), .Anode(c_an)
   );

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge Clk);
         #1;
         n_edge++;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Anode after edge n (counted from reset release): FE,FE,FD,FD,FE,...
   function automatic logic [7:0] exp_anode();
      return (((n_edge - 1) / 2) % 2 == 0) ? 8'hFE : 8'hFD;
   endfunction

   task automatic scan_chk(input string tag, input logic [7:0] an, input logic [7:0] disp,
                           input logic [7:0] d0, input logic [7:0] d1);
      logic [7:0] ea;
      ea = exp_anode();
      chk({tag, "_anode"}, an, ea);
      chk({tag, "_disp"}, disp, (ea == 8'hFE) ? d0 : d1);
   endtask

   initial begin
      // 1: reset and scan start
      step(3);
      chk("rst_anode", a_an, 8'hFF);
      chk("rst_disp", a_disp, 8'hFF);
      chk("rst_count", a_count, 8'h00);
      chk("rst_wrap", a_wrap, 1'b0);
      Reset  = 1'b1;
      n_edge = 0;
      step();
      chk("rel_anode", a_an, 8'hFE);
      chk("rel_disp", a_disp, 8'hC0);
      for (int i = 0; i < 4; i++) begin
         step();
         scan_chk("scan", a_an, a_disp, 8'hC0, 8'hC0);
      end

      // 2: count up 99 ticks then wrap to 00
      a_en = 1'b1;
      a_up = 1'b1;
      for (int i = 1; i <= 396; i++) begin
         step();
         chk("up_wrap_idle", a_wrap, 1'b0);
         if (i == 160) chk("up_count40", a_count, 8'h40);
      end
      chk("up_count99", a_count, 8'h99);
      step(3);
      chk("up_hold99", a_count, 8'h99);
      chk("up_prewrap", a_wrap, 1'b0);
      step();
      chk("up_roll_count", a_count, 8'h00);
      chk("up_roll_wrap", a_wrap, 1'b1);
      step();
      chk("up_wrap_once", a_wrap, 1'b0);

      // 3: count down from 00 after a clear realigns the prescaler
      a_up  = 1'b0;
      a_clr = 1'b1;
      step();
      a_clr = 1'b0;
      step(3);
      chk("dn_before", a_count, 8'h00);
      step();
      chk("dn_under_count", a_count, 8'h99);
      chk("dn_under_wrap", a_wrap, 1'b1);
      step(4);
      chk("dn_count98", a_count, 8'h98);
      chk("dn_wrap0", a_wrap, 1'b0);

      // 4: clear on a tick cycle at 37
      a_up  = 1'b1;
      a_clr = 1'b1;
      step();
      a_clr = 1'b0;
      step(148);
      chk("clr_count37", a_count, 8'h37);
      step(3);
      a_clr = 1'b1;
      step();
      chk("clr_count", a_count, 8'h00);
      chk("clr_wrap", a_wrap, 1'b0);
      a_clr = 1'b0;
      step(3);
      chk("clr_hold00", a_count, 8'h00);
      step();
      chk("clr_next01", a_count, 8'h01);

      // 5: En low holds 12 while scanning continues
      step(44);
      chk("en_count12", a_count, 8'h12);
      a_en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("en0_count", a_count, 8'h12);
         chk("en0_wrap", a_wrap, 1'b0);
         scan_chk("en0", a_an, a_disp, 8'hA4, 8'hF9);
      end

      // 6a: leading-zero blanking at 00 and 05
      for (int i = 0; i < 4; i++) begin
         step();
         scan_chk("lz00", b_an, b_disp, 8'hC0, 8'hFF);
      end
      b_en = 1'b1;
      step(20);
      b_en = 1'b0;
      chk("lz_count05", b_count, 8'h05);
      for (int i = 0; i < 4; i++) begin
         step();
         scan_chk("lz05", b_an, b_disp, 8'h92, 8'hFF);
      end

      // 6b: hex 0F -> 10
      c_en = 1'b1;
      step(60);
      c_en = 1'b0;
      chk("hex_count0F", c_count, 8'h0F);
      for (int i = 0; i < 4; i++) begin
         step();
         scan_chk("hex0F", c_an, c_disp, 8'h8E, 8'hC0);
      end
      c_en = 1'b1;
      step(3);
      chk("hex_hold0F", c_count, 8'h0F);
      step();
      chk("hex_count10", c_count, 8'h10);
      chk("hex_wrap0", c_wrap, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
